// File: rtl/rx_byte_fifo.sv
// Receive-side byte FIFO behind the UART receiver: edge-detects data_valid, filters and counts
// errored frames, and presents accepted bytes first-word-fall-through with sticky overflow.
module rx_byte_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DROP_ERR   = 1,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_data_valid,
    input  logic                     rx_par_err,
    input  logic                     rx_stp_err,
    input  logic                     rd_en,
    input  logic                     clr_stat,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_flag,
    output logic [CNT_WIDTH-1:0]     err_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_q, level_d;
    logic                  valid_q;
    logic                  ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

    logic wr_stb_c, err_c, keep_c, push_c, pop_c, ovf_evt_c, err_evt_c;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign level    = level_q;
    assign ovf_flag = ovf_q;
    assign err_cnt  = err_cnt_q;

    always_comb begin
        wr_stb_c  = rx_data_valid & ~valid_q;
        err_c     = rx_par_err | rx_stp_err;
        keep_c    = ~(err_c & (DROP_ERR != 0));
        pop_c     = rd_en & ~empty;
        push_c    = wr_stb_c & keep_c & (~full | pop_c);
        ovf_evt_c = wr_stb_c & keep_c & full & ~pop_c;
        err_evt_c = wr_stb_c & err_c;

        wr_ptr_d  = wr_ptr_q + PW'(push_c);
        rd_ptr_d  = rd_ptr_q + PW'(pop_c);
        level_d   = level_q + PW'(push_c) - PW'(pop_c);

        // A same-cycle event takes priority over the statistics clear.
        ovf_d = ovf_q;
        if (ovf_evt_c) begin
            ovf_d = 1'b1;
        end else if (clr_stat) begin
            ovf_d = 1'b0;
        end

        err_cnt_d = err_cnt_q;
        if (clr_stat) begin
            err_cnt_d = err_evt_c ? CNT_WIDTH'(1) : '0;
        end else if (err_evt_c && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            valid_q   <= rx_data_valid;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset; contents are only visible once pointers say so.
    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Scoreboard bench for rx_byte_fifo: stimulus queues expected bytes, a negedge monitor checks pops.
module tb_rx_byte_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_data_valid = 1'b0;
    logic       rx_par_err = 1'b0;
    logic       rx_stp_err = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_stat = 1'b0;
    logic       rd_en2 = 1'b0;

    logic [7:0] rd_data, rd_data2;
    logic       empty, full, ovf_flag, empty2, full2, ovf_flag2;
    logic [3:0] level, level2;
    logic [7:0] err_cnt, err_cnt2;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    rx_byte_fifo #(.DATA_WIDTH(8), .DEPTH(8), .DROP_ERR(1), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err), .rd_en(rd_en), .clr_stat(clr_stat),
        .rd_data(rd_data), .empty(empty), .full(full), .level(level),
        .ovf_flag(ovf_flag), .err_cnt(err_cnt)
    );

    rx_byte_fifo #(.DATA_WIDTH(8), .DEPTH(8), .DROP_ERR(0), .CNT_WIDTH(8)) dut_keep (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err), .rd_en(rd_en2), .clr_stat(clr_stat),
        .rd_data(rd_data2), .empty(empty2), .full(full2), .level(level2),
        .ovf_flag(ovf_flag2), .err_cnt(err_cnt2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every effective pop must present the oldest expected byte.
    always @(negedge CLK) begin
        if (RST && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
                check("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One valid pulse (one cycle high, one low); rd/clr apply to the high cycle.
    task automatic wr(input logic [7:0] d, input logic pe, input logic se,
                      input logic rd, input logic clr, input logic acc);
        rx_data = d; rx_data_valid = 1'b1; rx_par_err = pe; rx_stp_err = se;
        rd_en = rd; clr_stat = clr;
        if (acc) exp_q.push_back(d);
        tick();
        rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
        rd_en = 1'b0; clr_stat = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic clr();
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
    endtask

    initial begin
        // 1: reset state, then asynchronous reset mid-traffic
        repeat (2) tick();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        RST = 1'b1;
        tick();
        wr(8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wr(8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wr(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_level", 32'(level), 32'd2);
        check("pre_rst_errcnt", 32'(err_cnt), 32'd1);
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_full", 32'(full), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_ovf", 32'(ovf_flag), 32'd0);
        check("arst_errcnt", 32'(err_cnt), 32'd0);
        exp_q.delete();
        tick();
        RST = 1'b1;
        tick();

        // 3: error filter, dropping and keeping variants
        wr(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wr(8'h5B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("drop_level", 32'(level), 32'd0);
        check("drop_errcnt", 32'(err_cnt), 32'd2);
        check("keep_level", 32'(level2), 32'd2);
        check("keep_errcnt", 32'(err_cnt2), 32'd2);

        // 2: ordering
        wr(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wr(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wr(8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("order_level", 32'(level), 32'd3);
        check("order_head", 32'(rd_data), 32'h11);
        repeat (3) pop();
        check("order_empty", 32'(empty), 32'd1);

        // 4: full, overflow, drain, then push+pop while full
        for (int i = 0; i < 9; i++) wr(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, i < 8);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(ovf_flag), 32'd1);
        check("ovf_level", 32'(level), 32'd8);
        repeat (8) pop();
        check("drain_empty", 32'(empty), 32'd1);
        clr();
        check("clr_ovf", 32'(ovf_flag), 32'd0);
        check("clr_errcnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 8; i++) wr(8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("refill_full", 32'(full), 32'd1);
        wr(8'h18, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("pushpop_level", 32'(level), 32'd8);
        check("pushpop_ovf", 32'(ovf_flag), 32'd0);
        repeat (8) pop();
        check("drain2_empty", 32'(empty), 32'd1);

        // 5: held valid gives one write; pop while empty is ignored
        rx_data = 8'hC3; rx_data_valid = 1'b1;
        exp_q.push_back(8'hC3);
        repeat (5) tick();
        rx_data_valid = 1'b0;
        tick();
        check("held_level", 32'(level), 32'd1);
        pop();
        pop();
        check("empty_pop_level", 32'(level), 32'd0);
        check("empty_pop_empty", 32'(empty), 32'd1);

        // 6: wrap-around order, counter saturation, clear with concurrent error
        for (int i = 0; i < 40; i++) begin
            wr(8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            pop();
        end
        check("wrap_level", 32'(level), 32'd0);
        for (int i = 0; i < 300; i++) wr(8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_errcnt", 32'(err_cnt), 32'hFF);
        check("sat_level", 32'(level), 32'd0);
        clr();
        check("clr2_errcnt", 32'(err_cnt), 32'd0);
        wr(8'hEF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("clr_vs_err", 32'(err_cnt), 32'd1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
